// File: rtl/altpcierd_mrd_scheduler_pkg.sv
// altpcierd_dma_pkg: shared states, constants and sizing helper for the MRd scheduler
package altpcierd_dma_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SIZE, S_WAIT_CRED, S_ISSUE, S_HOLD, S_DRAIN} mrd_state_e;
    localparam int C_4K_BYTES = 4096;
    localparam int C_MAX_MRD_DW = 1024;
    function automatic logic [16:0] min3(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c);
        logic [16:0] m;
        m = a < b ? a : b;
        return m < c ? m : c;
    endfunction
endpackage

// File: rtl/altpcierd_mrd_scheduler_if.sv
// altpcierd_mrd_scheduler_if: descriptor, credit, MRd and completion signals of the scheduler
interface altpcierd_mrd_scheduler_if #(parameter int ADDR_W = 64);
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_addr;
    logic [15:0]       desc_len_dw;
    logic [10:0]       max_rd_req_dw;
    logic              cpld_rx_buffer_ready;
    logic [15:0]       rx_buffer_cpl_max_dw;
    logic              mrd_valid;
    logic              mrd_ready;
    logic [ADDR_W-1:0] mrd_addr;
    logic [9:0]        mrd_len_dw;
    logic [7:0]        mrd_tag;
    logic              cpl_last_valid;
    logic [7:0]        cpl_last_tag;
    logic              desc_done;
    logic [8:0]        tags_outstanding;
    logic              tag_err;
    modport slave (
        input  desc_valid, desc_addr, desc_len_dw, max_rd_req_dw, cpld_rx_buffer_ready,
               rx_buffer_cpl_max_dw, mrd_ready, cpl_last_valid, cpl_last_tag,
        output desc_ready, mrd_valid, mrd_addr, mrd_len_dw, mrd_tag, desc_done,
               tags_outstanding, tag_err
    );
    modport master (
        output desc_valid, desc_addr, desc_len_dw, max_rd_req_dw, cpld_rx_buffer_ready,
               rx_buffer_cpl_max_dw, mrd_ready, cpl_last_valid, cpl_last_tag,
        input  desc_ready, mrd_valid, mrd_addr, mrd_len_dw, mrd_tag, desc_done,
               tags_outstanding, tag_err
    );
endinterface

// File: rtl/altpcierd_mrd_scheduler_tag_pool.sv
// altpcierd_tag_pool: tag bitmap with lowest-free allocation, checked free and registered popcount
module altpcierd_tag_pool #(parameter int MAX_NUMTAG = 32) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       alloc,
    input  logic       free_valid,
    input  logic [7:0] free_tag,
    output logic       avail,
    output logic       empty,
    output logic [7:0] low_tag,
    output logic       tag_err,
    output logic [8:0] count
);
    logic [MAX_NUMTAG-1:0] map_q, map_d, free_oh, alloc_oh;
    logic       tag_err_q, tag_err_d;
    logic [8:0] count_q, count_d;
    always_comb begin
        low_tag = '0;
        avail = 1'b0;
        count_d = '0;
        free_oh = '0;
        alloc_oh = '0;
        for (int i = MAX_NUMTAG - 1; i >= 0; i--) begin
            if (!map_q[i]) begin
                low_tag = 8'(i);
                avail = 1'b1;
            end
        end
        for (int i = 0; i < MAX_NUMTAG; i++) begin
            free_oh[i] = free_valid && free_tag == 8'(i) && map_q[i];
            alloc_oh[i] = alloc && avail && low_tag == 8'(i);
            count_d = count_d + 9'(map_q[i]);
        end
        tag_err_d = free_valid && !(|free_oh);
        map_d = (map_q | alloc_oh) & ~free_oh;
    end
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            map_q <= '0;
            tag_err_q <= 1'b0;
            count_q <= '0;
        end else begin
            map_q <= map_d;
            tag_err_q <= tag_err_d;
            count_q <= count_d;
        end
    end
    assign empty = ~|map_q;
    assign tag_err = tag_err_q;
    assign count = count_q;
endmodule

// File: rtl/altpcierd_mrd_scheduler.sv
// altpcierd_mrd_scheduler: splits read descriptors into credit-gated, 4KB-safe tagged MRd requests
module altpcierd_mrd_scheduler
    import altpcierd_dma_pkg::*;
#(
    parameter int MAX_NUMTAG = 32,
    parameter int HOLDOFF_CYC = 6,
    parameter int ADDR_W = 64
) (
    input logic clk_in,
    input logic rst,
    altpcierd_mrd_scheduler_if.slave bus
);
    mrd_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, mrd_addr_q, mrd_addr_d;
    logic [15:0]       rem_q, rem_d, cpl_seen_q, cpl_seen_d, hold_q, hold_d;
    logic [10:0]       chunk_q, chunk_d;
    logic [9:0]        mrd_len_q, mrd_len_d;
    logic [7:0]        mrd_tag_q, mrd_tag_d, low_tag;
    logic              desc_ready_q, desc_ready_d, desc_done_q, desc_done_d;
    logic              mrd_valid_q, mrd_valid_d, alloc, avail, empty;
    logic [16:0]       bnd_dw;
    assign bnd_dw = (17'(C_4K_BYTES) - 17'(cur_addr_q[11:0])) >> 2;
    always_comb begin
        state_d = state_q;
        cur_addr_d = cur_addr_q;
        rem_d = rem_q;
        chunk_d = chunk_q;
        cpl_seen_d = cpl_seen_q;
        hold_d = hold_q;
        mrd_valid_d = mrd_valid_q;
        mrd_addr_d = mrd_addr_q;
        mrd_len_d = mrd_len_q;
        mrd_tag_d = mrd_tag_q;
        desc_done_d = 1'b0;
        alloc = 1'b0;
        case (state_q)
            S_IDLE: if (bus.desc_valid && desc_ready_q) begin
                cur_addr_d = bus.desc_addr;
                rem_d = bus.desc_len_dw;
                desc_done_d = bus.desc_len_dw == '0;
                state_d = bus.desc_len_dw == '0 ? S_IDLE : S_LOAD;
            end
            S_LOAD: state_d = S_SIZE;
            S_SIZE: begin
                chunk_d = 11'(min3(17'(rem_q), 17'(bus.max_rd_req_dw),
                                   min3(17'(bus.rx_buffer_cpl_max_dw), bnd_dw, 17'(C_MAX_MRD_DW))));
                cpl_seen_d = bus.rx_buffer_cpl_max_dw;
                state_d = S_WAIT_CRED;
            end
            // a credit estimate change invalidates the sized chunk
            S_WAIT_CRED: if (bus.rx_buffer_cpl_max_dw != cpl_seen_q) begin
                state_d = S_SIZE;
            end else if (bus.cpld_rx_buffer_ready && chunk_q != '0 && avail) begin
                alloc = 1'b1;
                mrd_valid_d = 1'b1;
                mrd_addr_d = cur_addr_q;
                mrd_len_d = chunk_q[9:0];
                mrd_tag_d = low_tag;
                state_d = S_ISSUE;
            end
            S_ISSUE: if (bus.mrd_ready) begin
                mrd_valid_d = 1'b0;
                cur_addr_d = cur_addr_q + ADDR_W'({chunk_q, 2'b00});
                rem_d = rem_q - 16'(chunk_q);
                hold_d = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                hold_d = hold_q + 16'd1;
                if (hold_q == 16'(HOLDOFF_CYC - 1)) state_d = rem_q != '0 ? S_SIZE : S_DRAIN;
            end
            S_DRAIN: if (empty) begin
                desc_done_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        desc_ready_d = state_d == S_IDLE;
    end
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_addr_q <= '0;
            rem_q <= '0;
            chunk_q <= '0;
            cpl_seen_q <= '0;
            hold_q <= '0;
            mrd_valid_q <= 1'b0;
            mrd_addr_q <= '0;
            mrd_len_q <= '0;
            mrd_tag_q <= '0;
            desc_ready_q <= 1'b0;
            desc_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q <= rem_d;
            chunk_q <= chunk_d;
            cpl_seen_q <= cpl_seen_d;
            hold_q <= hold_d;
            mrd_valid_q <= mrd_valid_d;
            mrd_addr_q <= mrd_addr_d;
            mrd_len_q <= mrd_len_d;
            mrd_tag_q <= mrd_tag_d;
            desc_ready_q <= desc_ready_d;
            desc_done_q <= desc_done_d;
        end
    end
    altpcierd_tag_pool #(.MAX_NUMTAG(MAX_NUMTAG)) u_pool (
        .clk_in(clk_in),
        .rst(rst),
        .alloc(alloc),
        .free_valid(bus.cpl_last_valid),
        .free_tag(bus.cpl_last_tag),
        .avail(avail),
        .empty(empty),
        .low_tag(low_tag),
        .tag_err(bus.tag_err),
        .count(bus.tags_outstanding)
    );
    assign bus.desc_ready = desc_ready_q;
    assign bus.desc_done = desc_done_q;
    assign bus.mrd_valid = mrd_valid_q;
    assign bus.mrd_addr = mrd_addr_q;
    assign bus.mrd_len_dw = mrd_len_q;
    assign bus.mrd_tag = mrd_tag_q;
endmodule
